// File: rtl/quad_decoder_counter.sv
// Quadrature encoder receiver: synchronise, glitch-filter and decode A/B
// phases into up/down steps that drive a wrapping position counter.
//
// Ports:
//   clk       system clock, all state on the rising edge
//   reset_n   asynchronous active-low reset
//   enc_a     raw phase A (asynchronous to clk)
//   enc_b     raw phase B (asynchronous to clk)
//   clear     synchronous count clear (wins over a coincident step)
//   count_en  1 = accumulate steps, 0 = hold count
//   err_clr   synchronous clear of the sticky error flag
//   count     position counter, wraps modulo 2^WIDTH
//   dir       direction of the last legal step (1 = up)
//   step      one-cycle pulse per legal step
//   err       sticky illegal (double-bit) transition flag
module quad_decoder_counter #(
    parameter int WIDTH = 4,
    parameter int FILT  = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             clear,
    input  logic             count_en,
    input  logic             err_clr,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             step,
    output logic             err
);

    localparam int CW = $clog2(FILT + 1);

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_TRACK = 1'b1;

    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    vld;
    logic [1:0]    cand;
    logic [CW-1:0] flt_cnt;
    logic [1:0]    ab_q;
    logic [0:0]    state;

    logic          acc;
    logic          up_t;
    logic          dn_t;
    logic          ill_t;

    logic          ev_up;
    logic          ev_dn;
    logic          ev_ill;

    // Synchroniser plus stability filter.  vld holds the filter off until
    // the synchroniser has flushed its reset value, so the reset zeros are
    // never mistaken for an encoder phase while priming.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1   <= 2'b00;
            sync2   <= 2'b00;
            vld     <= 2'b00;
            cand    <= 2'b00;
            flt_cnt <= '0;
        end else begin
            sync1 <= {enc_a, enc_b};
            sync2 <= sync1;
            vld   <= {vld[0], 1'b1};
            if (vld[1]) begin
                if (sync2 != cand) begin
                    cand    <= sync2;
                    flt_cnt <= CW'(1);
                end else if (flt_cnt != CW'(FILT)) begin
                    flt_cnt <= flt_cnt + CW'(1);
                end
            end
        end
    end

    // In INIT the first stable value is taken as-is; in TRACK only a
    // stable value that differs from the accepted phase counts.
    always_comb begin
        acc = (flt_cnt == CW'(FILT)) &&
              ((state == ST_INIT) || (cand != ab_q));
    end

    always_comb begin
        up_t  = 1'b0;
        dn_t  = 1'b0;
        ill_t = 1'b0;
        case ({ab_q, cand})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: up_t  = 1'b1;
            4'b0010, 4'b1011, 4'b1101, 4'b0100: dn_t  = 1'b1;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: ill_t = 1'b1;
            default: ;
        endcase
    end

    // Acceptance stage: latch the new phase and classify the transition.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ab_q   <= 2'b00;
            state  <= ST_INIT;
            ev_up  <= 1'b0;
            ev_dn  <= 1'b0;
            ev_ill <= 1'b0;
        end else begin
            ev_up  <= acc && (state == ST_TRACK) && up_t;
            ev_dn  <= acc && (state == ST_TRACK) && dn_t;
            ev_ill <= acc && (state == ST_TRACK) && ill_t;
            if (acc) begin
                ab_q  <= cand;
                state <= ST_TRACK;
            end
        end
    end

    // Output stage: step/dir always follow events, count obeys clear
    // then count_en, err set beats err_clr.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            dir   <= 1'b0;
            step  <= 1'b0;
            err   <= 1'b0;
        end else begin
            step <= ev_up | ev_dn;
            if (ev_up) begin
                dir <= 1'b1;
            end else if (ev_dn) begin
                dir <= 1'b0;
            end
            if (clear) begin
                count <= '0;
            end else if (count_en && ev_up) begin
                count <= count + WIDTH'(1);
            end else if (count_en && ev_dn) begin
                count <= count - WIDTH'(1);
            end
            if (ev_ill) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule
